// File: rtl/usb_rx_pkt_ctrl.sv
// Packet sequencer: pops receiver FIFO bytes, classifies by PID, decodes tokens and streams DATA payload minus CRC16.
// Completion/abort pulses land one cycle after resolution; payload pops stall while the out register is held by !out_ready.
module usb_rx_pkt_ctrl #(
  parameter int MAX_DATA = 64,
  parameter int LEN_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_empty,
  input  logic             rcving,
  input  logic             rx_error,
  output logic             r_enable,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [3:0]       pkt_pid,
  output logic [LEN_W-1:0] pkt_len,
  output logic [6:0]       tok_addr,
  output logic [3:0]       tok_endp,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_PID, S_TOK1, S_TOK2, S_HS, S_WEND, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pid_q;
  logic [7:0] h0, h1;
  logic [1:0] hold_cnt;
  logic       pop;
  logic       end_cond;
  logic       pid_ok;
  logic       abort;
  logic       data_pop;
  logic       len_ovf;
  logic       shift_out;

  assign end_cond = !rcving && rx_empty;
  assign pid_ok   = (pid_q[7:4] == ~pid_q[3:0]);
  assign abort    = rx_error && (state != S_IDLE) && (state != S_ERR);
  // A pop with both slots full displaces the oldest byte into the out register.
  assign data_pop = !rx_empty && ((hold_cnt != 2'd2) || !out_valid || out_ready);
  assign len_ovf  = (hold_cnt == 2'd2) && (pkt_len == LEN_W'(MAX_DATA));
  assign shift_out = (state == S_DATA) && pop && (hold_cnt == 2'd2) && !len_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (!rx_empty) state_nxt = S_PID;
      S_PID: begin
        if (!pid_ok) begin
          state_nxt = S_ERR;
        end else begin
          unique case (pid_q[3:0])
            4'b0001, 4'b1001, 4'b1101: state_nxt = S_TOK1;
            4'b0011, 4'b1011:          state_nxt = S_DATA;
            4'b0010, 4'b1010, 4'b1110: state_nxt = S_HS;
            default:                   state_nxt = S_ERR;
          endcase
        end
      end
      S_TOK1: begin
        if (!rx_empty)     state_nxt = S_TOK2;
        else if (end_cond) state_nxt = S_ERR;
      end
      S_TOK2: begin
        if (!rx_empty)     state_nxt = S_WEND;
        else if (end_cond) state_nxt = S_ERR;
      end
      S_HS, S_WEND: begin
        if (!rx_empty)     state_nxt = S_ERR;
        else if (end_cond) state_nxt = S_DONE;
      end
      S_DATA: begin
        if (data_pop && len_ovf) state_nxt = S_ERR;
        else if (end_cond)       state_nxt = (hold_cnt == 2'd2) ? S_DONE : S_ERR;
      end
      S_DONE: if (!out_valid) state_nxt = S_IDLE;
      S_ERR:  if (end_cond)   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_ERR;
  end

  always_comb begin
    pop = 1'b0;
    unique case (state)
      S_IDLE, S_TOK1, S_TOK2, S_ERR: pop = !rx_empty;
      S_DATA:                        pop = data_pop;
      default:                       pop = 1'b0;
    endcase
    if (abort) pop = 1'b0;
  end

  assign r_enable = pop && !rst;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      pkt_pid   <= '0;
      pkt_len   <= '0;
      tok_addr  <= '0;
      tok_endp  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      pid_q     <= '0;
      h0        <= '0;
      h1        <= '0;
      hold_cnt  <= '0;
    end else begin
      pkt_done <= (state == S_DONE) && (state_nxt == S_IDLE);
      pkt_err  <= (state == S_ERR) && (state_nxt == S_IDLE);

      if ((state == S_IDLE) && pop) begin
        pid_q    <= rx_data;
        pkt_pid  <= rx_data[3:0];
        pkt_len  <= '0;
        hold_cnt <= '0;
      end

      if ((state == S_TOK1) && pop) begin
        tok_addr    <= rx_data[6:0];
        tok_endp[0] <= rx_data[7];
      end
      if ((state == S_TOK2) && pop) tok_endp[3:1] <= rx_data[2:0];

      if ((state == S_DATA) && pop) begin
        h0 <= rx_data;
        h1 <= h0;
        if (hold_cnt != 2'd2) hold_cnt <= hold_cnt + 2'd1;
      end

      if (out_valid && out_ready) out_valid <= 1'b0;
      if (shift_out) begin
        out_data  <= h1;
        out_valid <= 1'b1;
        pkt_len   <= pkt_len + LEN_W'(1);
      end
      // Any abort drops the pending byte.
      if (state_nxt == S_ERR) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl: show-ahead FIFO model, stream monitor, hand-computed expectations.
module tb_usb_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data = 8'h00;
  logic       rx_empty = 1'b1;
  logic       rcving;
  logic       rx_error;
  logic       r_enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       pkt_done;
  logic       pkt_err;
  logic [3:0] pkt_pid;
  logic [6:0] pkt_len;
  logic [6:0] tok_addr;
  logic [3:0] tok_endp;
  logic       busy;

  usb_rx_pkt_ctrl #(.MAX_DATA(64), .LEN_W(7)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty), .rcving(rcving),
    .rx_error(rx_error), .r_enable(r_enable), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .pkt_done(pkt_done), .pkt_err(pkt_err), .pkt_pid(pkt_pid),
    .pkt_len(pkt_len), .tok_addr(tok_addr), .tok_endp(tok_endp), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO contents are stim[rd_idx .. stim_n-1]; the stimulus only appends.
  logic [7:0] stim [0:1023];
  int         stim_n = 0;
  int         rd_idx = 0;
  logic       pop_arm = 1'b0;

  always @(negedge clk) pop_arm = r_enable;

  always @(posedge clk) begin
    #1;
    if (pop_arm) rd_idx++;
    rx_empty = (rd_idx >= stim_n);
    rx_data  = rx_empty ? 8'h00 : stim[rd_idx];
  end

  logic [7:0] out_log [0:255];
  int   out_n = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   pop_cnt = 0, bad_pop = 0, unstable = 0;
  logic prv_vld = 1'b0, prv_rdy = 1'b0;
  logic [7:0] prv_dat = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        out_log[out_n] = out_data;
        out_n++;
      end
      if (pkt_done) done_cnt++;
      if (pkt_err) err_cnt++;
      if (pkt_done && pkt_err) both_cnt++;
      if (r_enable) pop_cnt++;
      if (r_enable && rx_empty) bad_pop++;
      if (prv_vld && !prv_rdy && out_valid && (out_data != prv_dat)) unstable++;
    end else if (r_enable) begin
      bad_pop++;
    end
    prv_vld = out_valid;
    prv_rdy = out_ready;
    prv_dat = out_data;
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    stim[stim_n] = b;
    stim_n++;
  endtask

  task automatic wait_end(input string tag);
    int  base;
    bit  seen;
    base = done_cnt + err_cnt;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt + err_cnt != base) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_end_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int d0, e0, n0, p0;

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
    n0 = out_n;
    p0 = pop_cnt;
  endtask

  initial begin
    rst = 1'b1; rcving = 1'b0; rx_error = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    // Token IN loaded while reset holds: nothing may be popped.
    push(8'h69); push(8'h81); push(8'h00);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_r_enable", 32'(r_enable), 32'd0);
    chk("rst_fifo_level", 32'(stim_n - rd_idx), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outputs", 32'({out_valid, pkt_done, pkt_err, pkt_pid, pkt_len, tok_addr, tok_endp, out_data}), 32'd0);
    tick();
    snap();
    rst = 1'b0;
    wait_end("tok_in");
    chk("tok_done", 32'(done_cnt - d0), 32'd1);
    chk("tok_err", 32'(err_cnt - e0), 32'd0);
    chk("tok_pid", 32'(pkt_pid), 32'h9);
    chk("tok_addr", 32'(tok_addr), 32'h01);
    chk("tok_endp", 32'(tok_endp), 32'h1);
    chk("tok_no_out", 32'(out_n - n0), 32'd0);
    chk("tok_idle", 32'(busy), 32'd0);

    // DATA0 with three payload bytes, downstream always ready.
    tick(); snap();
    push(8'hC3); push(8'h11); push(8'h22); push(8'h33); push(8'hAA); push(8'hBB);
    wait_end("data0");
    chk("d0_done", 32'(done_cnt - d0), 32'd1);
    chk("d0_err", 32'(err_cnt - e0), 32'd0);
    chk("d0_count", 32'(out_n - n0), 32'd3);
    chk("d0_b0", 32'(out_log[n0]), 32'h11);
    chk("d0_b1", 32'(out_log[n0+1]), 32'h22);
    chk("d0_b2", 32'(out_log[n0+2]), 32'h33);
    chk("d0_len", 32'(pkt_len), 32'd3);
    chk("d0_pid", 32'(pkt_pid), 32'h3);

    // Same packet with downstream stalled.
    tick(); snap();
    out_ready = 1'b0;
    push(8'hC3); push(8'h11); push(8'h22); push(8'h33); push(8'hAA); push(8'hBB);
    repeat (16) @(negedge clk);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_data", 32'(out_data), 32'h11);
    chk("stall_pops", 32'(pop_cnt - p0), 32'd4);
    chk("stall_fifo_level", 32'(stim_n - rd_idx), 32'd2);
    tick();
    out_ready = 1'b1;
    wait_end("stall");
    chk("stall_done", 32'(done_cnt - d0), 32'd1);
    chk("stall_count", 32'(out_n - n0), 32'd3);
    chk("stall_b0", 32'(out_log[n0]), 32'h11);
    chk("stall_b2", 32'(out_log[n0+2]), 32'h33);

    // PID A5 (SOF, not handled here) followed by two bytes.
    tick(); snap();
    push(8'hA5); push(8'h12); push(8'h34);
    wait_end("pid_a5");
    chk("a5_err", 32'(err_cnt - e0), 32'd1);
    chk("a5_done", 32'(done_cnt - d0), 32'd0);
    chk("a5_pops", 32'(pop_cnt - p0), 32'd3);
    chk("a5_drained", 32'(stim_n - rd_idx), 32'd0);

    // Broken complement D1.
    tick(); snap();
    push(8'hD1); push(8'h55); push(8'h66);
    wait_end("pid_bad");
    chk("bad_err", 32'(err_cnt - e0), 32'd1);
    chk("bad_done", 32'(done_cnt - d0), 32'd0);
    chk("bad_drained", 32'(stim_n - rd_idx), 32'd0);

    // ACK with a trailing byte.
    tick(); snap();
    push(8'hD2); push(8'h00);
    wait_end("ack_extra");
    chk("ack_err", 32'(err_cnt - e0), 32'd1);
    chk("ack_done", 32'(done_cnt - d0), 32'd0);
    chk("ack_pid", 32'(pkt_pid), 32'h2);

    // DATA1 with a single byte after the PID.
    tick(); snap();
    push(8'h4B); push(8'h77);
    wait_end("data1_short");
    chk("short_err", 32'(err_cnt - e0), 32'd1);
    chk("short_done", 32'(done_cnt - d0), 32'd0);
    chk("short_no_out", 32'(out_n - n0), 32'd0);

    // MAX_DATA+3 bytes after the PID: 64 forwarded, then abort.
    tick(); snap();
    push(8'hC3);
    for (int i = 1; i <= 67; i++) push(8'(i));
    wait_end("overflow");
    chk("ovf_err", 32'(err_cnt - e0), 32'd1);
    chk("ovf_done", 32'(done_cnt - d0), 32'd0);
    chk("ovf_count", 32'(out_n - n0), 32'd64);
    chk("ovf_last", 32'(out_log[n0+63]), 32'h40);
    chk("ovf_len", 32'(pkt_len), 32'd64);
    chk("ovf_drained", 32'(stim_n - rd_idx), 32'd0);

    // rx_error while a payload byte waits on a stalled downstream.
    tick(); snap();
    out_ready = 1'b0;
    rcving = 1'b1;
    push(8'hC3); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (10) tick();
    @(negedge clk);
    chk("rxe_pre_valid", 32'(out_valid), 32'd1);
    tick();
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    @(negedge clk);
    chk("rxe_valid_drop", 32'(out_valid), 32'd0);
    chk("rxe_busy", 32'(busy), 32'd1);
    tick();
    rcving = 1'b0;
    wait_end("rx_error");
    chk("rxe_err", 32'(err_cnt - e0), 32'd1);
    chk("rxe_done", 32'(done_cnt - d0), 32'd0);
    chk("rxe_no_out", 32'(out_n - n0), 32'd0);
    chk("rxe_drained", 32'(stim_n - rd_idx), 32'd0);
    out_ready = 1'b1;

    // rx_error while idle has no effect.
    tick(); snap();
    rx_error = 1'b1;
    repeat (2) tick();
    rx_error = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_rxe_busy", 32'(busy), 32'd0);
    chk("idle_rxe_err", 32'(err_cnt - e0), 32'd0);

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("no_pop_when_empty", 32'(bad_pop), 32'd0);
    chk("stream_stable", 32'(unstable), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
